id_ex_stage: RTL and testbench

// - ID/EX pipeline register of the pipelined core: latches register-file read data, rd and

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand bypass and a load-use stall FSM.
// The register file writes on negedge, so no WB bypass path is needed here.
module id_ex_stage #(
  parameter int XLEN     = 64,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_csrrs,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [15:0]     id_ctrl,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_bubble,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_is_load,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [15:0]     ex_ctrl
);

  // Counter holds the remaining extra bubbles after the first one (0..LOAD_LAT-2).
  localparam int CNT_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic            rs1_match;
  logic            rs2_match;
  logic            hazard;
  logic            issue;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Load-use hazard: a load in EX whose rd is needed by the instruction in ID.
  always_comb begin
    rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_uses_rs2 && !id_csrrs && (id_rs2 == ex_rd);
    hazard    = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                (rs1_match || rs2_match);
    stall_id  = !flush && (((state == RUN) && hazard) || (state == STALL));
    issue     = !flush && (state == RUN) && !hazard;
  end

  // Operand bypass; the EX result wins over MEM, and CSR data on rs2 is never replaced.
  always_comb begin
    rs1_fwd = id_rs1_data;
    rs2_fwd = id_rs2_data;
    if (ex_valid && ex_we && !ex_is_load && (ex_rd != 5'd0) && (ex_rd == id_rs1)) begin
      rs1_fwd = ex_alu_result;
    end else if (mem_we && (mem_rd != 5'd0) && (mem_rd == id_rs1)) begin
      rs1_fwd = mem_result;
    end
    if (!id_csrrs) begin
      if (ex_valid && ex_we && !ex_is_load && (ex_rd != 5'd0) && (ex_rd == id_rs2)) begin
        rs2_fwd = ex_alu_result;
      end else if (mem_we && (mem_rd != 5'd0) && (mem_rd == id_rs2)) begin
        rs2_fwd = mem_result;
      end
    end
  end

  // Stall FSM next state: the first bubble clears ex_is_load, so the remaining
  // LOAD_LAT-1 bubbles must be counted here rather than re-detected.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (state == RUN) begin
      if (hazard && (LOAD_LAT > 1)) begin
        state_nxt = STALL;
        cnt_nxt   = CNT_INIT;
      end
    end else begin
      if (cnt == '0) begin
        state_nxt = RUN;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  // Stall FSM state register; reset aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ID/EX register: issue the ID instruction or insert a bubble that holds data/ctrl.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_bubble   <= 1'b1;
      ex_rd       <= 5'd0;
      ex_we       <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_ctrl     <= 16'd0;
    end else if (issue) begin
      ex_valid    <= id_valid;
      ex_bubble   <= !id_valid;
      ex_rd       <= id_rd;
      ex_we       <= id_we && id_valid;
      ex_is_load  <= id_is_load;
      ex_rs1_data <= rs1_fwd;
      ex_rs2_data <= rs2_fwd;
      ex_ctrl     <= id_ctrl;
    end else begin
      ex_valid    <= 1'b0;
      ex_bubble   <= 1'b1;
      ex_we       <= 1'b0;
      ex_is_load  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: one instance with LOAD_LAT=1 and one with
// LOAD_LAT=3 share the same stimulus so stall lengths can be compared side by side.
module tb_id_ex_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_we;
  logic            id_is_load;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            id_csrrs;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [15:0]     id_ctrl;
  logic [XLEN-1:0] ex_alu_result;
  logic            mem_we;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_result;

  logic            a_stall, a_valid, a_bubble, a_we, a_load;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_rs1, a_rs2;
  logic [15:0]     a_ctrl;

  logic            b_stall, b_valid, b_bubble, b_we, b_load;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_rs1, b_rs2;
  logic [15:0]     b_ctrl;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .LOAD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_csrrs(id_csrrs), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_ctrl(id_ctrl), .ex_alu_result(ex_alu_result), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_result(mem_result), .stall_id(a_stall),
    .ex_valid(a_valid), .ex_bubble(a_bubble), .ex_rd(a_rd), .ex_we(a_we),
    .ex_is_load(a_load), .ex_rs1_data(a_rs1), .ex_rs2_data(a_rs2), .ex_ctrl(a_ctrl)
  );

  id_ex_stage #(.XLEN(XLEN), .LOAD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_csrrs(id_csrrs), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_ctrl(id_ctrl), .ex_alu_result(ex_alu_result), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_result(mem_result), .stall_id(b_stall),
    .ex_valid(b_valid), .ex_bubble(b_bubble), .ex_rd(b_rd), .ex_we(b_we),
    .ex_is_load(b_load), .ex_rs1_data(b_rs1), .ex_rs2_data(b_rs2), .ex_ctrl(b_ctrl)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put an instruction into ID; operand usage and data set separately.
  task automatic drive_id(input logic v, input logic [4:0] rd, input logic we,
                          input logic ld, input logic [15:0] ctrl);
    id_valid    = v;
    id_rd       = rd;
    id_we       = we;
    id_is_load  = ld;
    id_ctrl     = ctrl;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    id_csrrs    = 1'b0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    mem_we      = 1'b0;
    mem_rd      = 5'd0;
  endtask

  // Drain with an invalid ID instruction so EX holds nothing.
  task automatic idle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0, 16'h0);
    flush = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive_id(1'b0, 5'd0, 1'b0, 1'b0, 16'h0);
    id_rs1_data = '0; id_rs2_data = '0; ex_alu_result = '0; mem_result = '0;
    step(); step();
    tests_run++; if (a_bubble !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_bubble got %b want 1", a_bubble); end
    tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", a_valid); end
    tests_run++; if (a_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we got %b want 0", a_we); end
    tests_run++; if (a_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall got %b want 0", a_stall); end
    tests_run++; if (b_bubble !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_bubble_b got %b want 1", b_bubble); end
    tests_run++; if (a_rs1 !== 64'h0 || a_ctrl !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h/%h want 0/0", a_rs1, a_ctrl); end
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    idle();
    drive_id(1'b1, 5'd5, 1'b1, 1'b0, 16'hA5A5);
    step();
    tests_run++; if (a_valid !== 1'b1 || a_rd !== 5'd5 || a_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL issue_add got v%b rd%0d we%b want v1 rd5 we1", a_valid, a_rd, a_we); end
    tests_run++; if (a_ctrl !== 16'hA5A5) begin tests_failed++; $display("[TB] FAIL issue_ctrl got %h want a5a5", a_ctrl); end
    // EX and MEM both hold x5; EX must win
    drive_id(1'b1, 5'd6, 1'b1, 1'b0, 16'h0001);
    id_uses_rs1 = 1'b1; id_rs1 = 5'd5; id_rs1_data = 64'hDEAD;
    id_uses_rs2 = 1'b1; id_rs2 = 5'd4; id_rs2_data = 64'hBEEF;
    ex_alu_result = 64'h2A;
    mem_we = 1'b1; mem_rd = 5'd5; mem_result = 64'h11;
    #1;
    tests_run++; if (a_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL bypass_nostall got %b want 0", a_stall); end
    step();
    tests_run++; if (a_rs1 !== 64'h2A) begin tests_failed++; $display("[TB] FAIL ex_bypass_rs1 got %h want 2a", a_rs1); end
    tests_run++; if (a_rs2 !== 64'hBEEF) begin tests_failed++; $display("[TB] FAIL rf_rs2 got %h want beef", a_rs2); end
    // MEM-only match on rs1, EX (x6) match on rs2
    drive_id(1'b1, 5'd10, 1'b1, 1'b0, 16'h0002);
    id_uses_rs1 = 1'b1; id_rs1 = 5'd9; id_rs1_data = 64'h1;
    id_uses_rs2 = 1'b1; id_rs2 = 5'd6; id_rs2_data = 64'h2;
    ex_alu_result = 64'h3C;
    mem_we = 1'b1; mem_rd = 5'd9; mem_result = 64'h11;
    step();
    tests_run++; if (a_rs1 !== 64'h11) begin tests_failed++; $display("[TB] FAIL mem_bypass_rs1 got %h want 11", a_rs1); end
    tests_run++; if (b_rs2 !== 64'h3C) begin tests_failed++; $display("[TB] FAIL ex_bypass_rs2 got %h want 3c", b_rs2); end
    // invalid ID issues a bubble even with id_we set
    drive_id(1'b0, 5'd3, 1'b1, 1'b0, 16'h0003);
    step();
    tests_run++; if (a_we !== 1'b0 || a_bubble !== 1'b1) begin tests_failed++; $display("[TB] FAIL invalid_issue got we%b bub%b want we0 bub1", a_we, a_bubble); end
  endtask

  task automatic test_load_use();
    idle();
    drive_id(1'b1, 5'd7, 1'b1, 1'b1, 16'h00F0);
    step();
    drive_id(1'b1, 5'd8, 1'b1, 1'b0, 16'h00F1);
    id_uses_rs2 = 1'b1; id_rs2 = 5'd7; id_rs2_data = 64'h99;
    mem_we = 1'b1; mem_rd = 5'd7; mem_result = 64'h77;
    ex_alu_result = 64'hFFFF;
    #1;
    tests_run++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_stall_c0 got %b/%b want 1/1", a_stall, b_stall); end
    step();
    tests_run++; if (a_bubble !== 1'b1 || b_bubble !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_bubble1 got %b/%b want 1/1", a_bubble, b_bubble); end
    tests_run++; if (a_stall !== 1'b0 || b_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_stall_c1 got %b/%b want 0/1", a_stall, b_stall); end
    step();
    tests_run++; if (a_valid !== 1'b1 || a_rs2 !== 64'h77 || a_rd !== 5'd8) begin tests_failed++; $display("[TB] FAIL lat1_issue got v%b %h rd%0d want v1 77 rd8", a_valid, a_rs2, a_rd); end
    tests_run++; if (b_bubble !== 1'b1 || b_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat3_c2 got bub%b st%b want 1/1", b_bubble, b_stall); end
    step();
    tests_run++; if (b_bubble !== 1'b1 || b_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat3_c3 got bub%b st%b want 1/0", b_bubble, b_stall); end
    step();
    tests_run++; if (b_valid !== 1'b1 || b_rs2 !== 64'h77 || b_ctrl !== 16'h00F1) begin tests_failed++; $display("[TB] FAIL lat3_issue got v%b %h %h want v1 77 00f1", b_valid, b_rs2, b_ctrl); end
  endtask

  task automatic test_flush_stall();
    idle();
    drive_id(1'b1, 5'd7, 1'b1, 1'b1, 16'h0100);
    step();
    drive_id(1'b1, 5'd8, 1'b1, 1'b0, 16'h0101);
    id_uses_rs2 = 1'b1; id_rs2 = 5'd7;
    step();
    tests_run++; if (b_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_pre got %b want 1", b_stall); end
    flush = 1'b1;
    #1;
    tests_run++; if (b_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_comb got %b want 0", b_stall); end
    step();
    flush = 1'b0;
    #1;
    tests_run++; if (b_bubble !== 1'b1 || b_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_after got bub%b st%b want 1/0", b_bubble, b_stall); end
    step();
    tests_run++; if (b_valid !== 1'b1 || b_ctrl !== 16'h0101) begin tests_failed++; $display("[TB] FAIL flush_resume got v%b %h want v1 0101", b_valid, b_ctrl); end
  endtask

  task automatic test_csrrs();
    idle();
    drive_id(1'b1, 5'd7, 1'b1, 1'b1, 16'h0200);
    step();
    drive_id(1'b1, 5'd9, 1'b1, 1'b0, 16'h0201);
    id_uses_rs2 = 1'b1; id_rs2 = 5'd7; id_csrrs = 1'b1; id_rs2_data = 64'h55;
    mem_we = 1'b1; mem_rd = 5'd7; mem_result = 64'h77;
    #1;
    tests_run++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL csrrs_stall got %b/%b want 0/0", a_stall, b_stall); end
    step();
    tests_run++; if (a_valid !== 1'b1 || a_rs2 !== 64'h55) begin tests_failed++; $display("[TB] FAIL csrrs_data got v%b %h want v1 55", a_valid, a_rs2); end
  endtask

  task automatic test_x0();
    idle();
    drive_id(1'b1, 5'd0, 1'b1, 1'b1, 16'h0300);
    step();
    drive_id(1'b1, 5'd0, 1'b1, 1'b0, 16'h0301);
    id_uses_rs1 = 1'b1; id_rs1 = 5'd0; id_rs1_data = 64'h123;
    id_uses_rs2 = 1'b1; id_rs2 = 5'd0; id_rs2_data = 64'h456;
    mem_we = 1'b1; mem_rd = 5'd0; mem_result = 64'h77;
    ex_alu_result = 64'hAA;
    #1;
    tests_run++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL x0_stall got %b/%b want 0/0", a_stall, b_stall); end
    step();
    tests_run++; if (a_rs1 !== 64'h123 || a_rs2 !== 64'h456) begin tests_failed++; $display("[TB] FAIL x0_load_use got %h/%h want 123/456", a_rs1, a_rs2); end
    // EX now holds a non-load write to x0; still no bypass
    id_rs1_data = 64'h321; id_rs2_data = 64'h654;
    step();
    tests_run++; if (a_rs1 !== 64'h321 || a_rs2 !== 64'h654) begin tests_failed++; $display("[TB] FAIL x0_alu got %h/%h want 321/654", a_rs1, a_rs2); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive_id(1'b1, 5'd7, 1'b1, 1'b1, 16'h0400);
    step();
    drive_id(1'b1, 5'd8, 1'b1, 1'b0, 16'h0401);
    id_uses_rs1 = 1'b1; id_rs1 = 5'd7;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    tests_run++; if (b_stall !== 1'b0 || b_bubble !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_mid_stall got st%b bub%b want 0/1", b_stall, b_bubble); end
    step();
    tests_run++; if (b_valid !== 1'b1 || b_ctrl !== 16'h0401) begin tests_failed++; $display("[TB] FAIL reset_resume got v%b %h want v1 0401", b_valid, b_ctrl); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_csrrs();
    test_x0();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
